// File: rtl/serial_divider_8bit_pkg.sv
// Shared types and sizing for the serial restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int unsigned div_cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_divider_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the serial divider.
interface serial_divider_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/serial_divider_8bit_trial_subtractor.sv
// Combinational N-bit trial subtraction; borrow is the sign bit of the difference.
module trial_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    always_comb begin
        diff   = a - b;
        borrow = diff[N-1];
    end
endmodule

// File: rtl/serial_divider_8bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
module serial_divider_8bit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    serial_divider_8bit_if.slave bus
);
    localparam int unsigned CW = div_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH:0]   p, p_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] dvsr, dvsr_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic             dbz, dbz_n;
    logic             busy_r, done_r;

    logic [WIDTH:0]   trial_a, trial_b, trial_diff;
    logic             trial_borrow;

    // Shift the next dividend bit into the partial remainder before the trial.
    always_comb begin
        trial_a = {p[WIDTH-1:0], q[WIDTH-1]};
        trial_b = {1'b0, dvsr};
    end

    trial_subtractor #(.N(WIDTH + 1)) u_trial (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p;
        q_n     = q;
        dvsr_n  = dvsr;
        quo_n   = quo;
        rem_n   = rem;
        dbz_n   = dbz;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvsr_n = bus.divisor;
                    if (bus.divisor == '0) begin
                        state_n = DONE;
                        quo_n   = '1;
                        rem_n   = bus.dividend;
                        dbz_n   = 1'b1;
                    end else begin
                        state_n = RUN;
                        cnt_n   = CNT_LAST;
                        p_n     = '0;
                        q_n     = bus.dividend;
                        dbz_n   = 1'b0;
                    end
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                p_n   = trial_borrow ? trial_a : trial_diff;
                q_n   = {q[WIDTH-2:0], ~trial_borrow};
                cnt_n = cnt - 1'b1;
                if (cnt == '0) begin
                    state_n = DONE;
                    quo_n   = q_n;
                    rem_n   = p_n[WIDTH-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= '0;
            q      <= '0;
            dvsr   <= '0;
            quo    <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            p      <= p_n;
            q      <= q_n;
            dvsr   <= dvsr_n;
            quo    <= quo_n;
            rem    <= rem_n;
            dbz    <= dbz_n;
            busy_r <= (state_n == RUN);
            done_r <= (state_n == DONE);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_serial_divider_8bit.sv
// Directed-vector bench for serial_divider_8bit with hand-computed results.
module tb_serial_divider_8bit;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_divider_8bit_if #(.WIDTH(W)) dif ();

    serial_divider_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or budget expires).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int off);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        dif.start = 1'b0;
        off = 0;
        while (!dif.done && off < 20) begin
            @(negedge clk);
            off++;
        end
    endtask

    task automatic check_result(input string tag, input int off_exp, input int off,
                                input int q_exp, input int r_exp, input int z_exp);
        check({tag, "_latency"}, off, off_exp);
        check({tag, "_done"}, int'(dif.done), 1);
        check({tag, "_quotient"}, int'(dif.quotient), q_exp);
        check({tag, "_remainder"}, int'(dif.remainder), r_exp);
        check({tag, "_dbz"}, int'(dif.div_by_zero), z_exp);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dif.done) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        int pulses;

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(dif.busy), 0);
        check("rst_done", int'(dif.done), 0);
        check("rst_quotient", int'(dif.quotient), 0);
        check("rst_remainder", int'(dif.remainder), 0);
        check("rst_dbz", int'(dif.div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd200, 8'd7, off);
        check_result("d200_7", 8, off, 28, 4, 0);
        @(negedge clk);
        check("d200_7_pulse_end", int'(dif.done), 0);
        check("d200_7_held_q", int'(dif.quotient), 28);
        @(negedge clk);

        run_op(8'd255, 8'd1, off);
        check_result("d255_1", 8, off, 255, 0, 0);
        @(negedge clk);
        run_op(8'd5, 8'd9, off);
        check_result("d5_9", 8, off, 0, 5, 0);
        @(negedge clk);

        run_op(8'd42, 8'd0, off);
        check_result("d42_0", 0, off, 255, 42, 1);
        @(negedge clk);
        check("d42_0_pulse_end", int'(dif.done), 0);
        check("d42_0_dbz_held", int'(dif.div_by_zero), 1);

        run_op(8'd7, 8'd7, off);
        check_result("d7_7", 8, off, 1, 0, 0);
        @(negedge clk);

        // start pulsed with other operands while 100/10 is running
        dif.start    = 1'b1;
        dif.dividend = 8'd100;
        dif.divisor  = 8'd10;
        @(negedge clk);
        dif.start = 1'b0;
        off = 0;
        pulses = 0;
        while (!dif.done && off < 20) begin
            if (off == 2) begin
                dif.start    = 1'b1;
                dif.dividend = 8'd10;
                dif.divisor  = 8'd3;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            off++;
        end
        dif.start = 1'b0;
        check_result("midrun_start", 8, off, 10, 0, 0);
        count_done(12, pulses);
        check("midrun_extra_done", pulses, 0);
        check("midrun_busy_after", int'(dif.busy), 0);

        // back-to-back: second start issued on the DONE cycle
        run_op(8'd100, 8'd10, off);
        check_result("b2b_first", 8, off, 10, 0, 0);
        run_op(8'd9, 8'd2, off);
        check_result("b2b_second", 8, off, 4, 1, 0);
        @(negedge clk);
        check("b2b_pulse_end", int'(dif.done), 0);

        // reset three cycles into 77/5
        dif.start    = 1'b1;
        dif.dividend = 8'd77;
        dif.divisor  = 8'd5;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", int'(dif.busy), 1);
        rst = 1'b1;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        check("abort_busy", int'(dif.busy), 0);
        check("abort_done", int'(dif.done), 0);
        check("abort_quotient", int'(dif.quotient), 0);
        check("abort_remainder", int'(dif.remainder), 0);
        check("abort_dbz", int'(dif.div_by_zero), 0);
        rst = 1'b0;
        count_done(12, pulses);
        check("abort_no_done", pulses, 0);
        check("abort_idle_busy", int'(dif.busy), 0);

        run_op(8'd77, 8'd5, off);
        check_result("d77_5", 8, off, 15, 2, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
